// File: rtl/pipe_rx_detect_seq.sv
// pipe_rx_detect_seq
//   Runs PIPE receiver detection on all lanes for the LTSSM Detect state.
//   Holds the lanes in P1 with electrical idle, requests detect, collects
//   per-lane PhyStatus/RxStatus, retries once on an empty result and flags
//   lanes whose PHY never answered.
//   Optional feature: define RXDET_LANE_MASK_EN to add i_lane_enable, which is
//   sampled on start and removes lanes from detect and from completion.
//
//   state     | meaning
//   S_IDLE    | waiting for start, results held
//   S_SETUP   | P1 + electrical idle settling, SETUP_CYCLES long
//   S_DETECT  | detect requested, collecting PhyStatus until all lanes or timeout
//   S_RELEASE | detect request dropped for one cycle, decide retry or finish
//   S_DONE    | one-cycle done pulse
module pipe_rx_detect_seq #(
  parameter int LANESNUMBER    = 16,
  parameter int SETUP_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RETRY_MAX      = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [LANESNUMBER-1:0]   i_phy_status,
  input  logic [3*LANESNUMBER-1:0] i_rx_status,
`ifdef RXDET_LANE_MASK_EN
  input  logic [LANESNUMBER-1:0]   i_lane_enable,
`endif
  output logic [4*LANESNUMBER-1:0] o_power_down,
  output logic [LANESNUMBER-1:0]   o_tx_elec_idle,
  output logic [LANESNUMBER-1:0]   o_tx_detect_rx_loopback,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [LANESNUMBER-1:0]   o_detected_lanes,
  output logic                     o_timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SETUP_LOAD = SW'(SETUP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);
  localparam logic [3:0]    PD_P1      = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_DETECT, S_RELEASE, S_DONE
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [SW-1:0]          r_setup_cnt;
  logic [TW-1:0]          r_to_cnt;
  logic [RW-1:0]          r_retry;
  logic [LANESNUMBER-1:0] r_got;
  logic [LANESNUMBER-1:0] r_detected;
  logic                   r_timeout_err;

  logic [LANESNUMBER-1:0] w_lane_en;
  logic [LANESNUMBER-1:0] w_rx_ok;
  logic [LANESNUMBER-1:0] w_new_status;
  logic [LANESNUMBER-1:0] w_got_nxt;
  logic                   w_all_done;
  logic                   w_seq_start;
  logic                   w_retry;
  logic                   w_timeout_hit;
  logic [LANESNUMBER-1:0] w_loopback;

`ifdef RXDET_LANE_MASK_EN
  logic [LANESNUMBER-1:0] r_lane_en;

  // Lane mask is frozen for the whole sequence at start.
  always_ff @(posedge i_clk) begin
    if (i_reset)          r_lane_en <= '0;
    else if (w_seq_start) r_lane_en <= i_lane_enable;
  end

  assign w_lane_en = r_lane_en;
`else
  assign w_lane_en = '1;
`endif

  // Per-lane "receiver present" decode of RxStatus.
  always_comb begin
    w_rx_ok = '0;
    for (int l = 0; l < LANESNUMBER; l++)
      w_rx_ok[l] = (i_rx_status[3*l +: 3] == 3'b011);
  end

  // First PhyStatus per enabled lane counts; later ones are ignored.
  assign w_new_status = (r_state == S_DETECT) ? (i_phy_status & w_lane_en & ~r_got) : '0;
  assign w_got_nxt    = r_got | w_new_status;
  assign w_all_done   = ((w_got_nxt & w_lane_en) == w_lane_en);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_seq_start   = 1'b0;
    w_retry       = 1'b0;
    w_timeout_hit = 1'b0;
    w_loopback    = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SETUP;
          w_seq_start = 1'b1;
        end
      end
      S_SETUP: begin
        if (r_setup_cnt == '0) w_state_nxt = S_DETECT;
      end
      S_DETECT: begin
        w_loopback = w_lane_en;
        // Completion takes priority over a coincident timeout.
        if (w_all_done) begin
          w_state_nxt = S_RELEASE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt   = S_RELEASE;
          w_timeout_hit = 1'b1;
        end
      end
      S_RELEASE: begin
        if ((r_detected == '0) && (r_retry < RETRY_LIM) && !r_timeout_err) begin
          w_state_nxt = S_SETUP;
          w_retry     = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Setup down-counter: loaded on every SETUP entry, leaves SETUP at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset)                                    r_setup_cnt <= '0;
    else if (w_seq_start || w_retry)                r_setup_cnt <= SETUP_LOAD;
    else if (r_state == S_SETUP && r_setup_cnt != '0) r_setup_cnt <= r_setup_cnt - 1'b1;
  end

  // Timeout counter: zero outside DETECT, counts up and saturates inside it.
  always_ff @(posedge i_clk) begin
    if (i_reset || r_state != S_DETECT) r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST)       r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Status collection, results and retry bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_got         <= '0;
      r_detected    <= '0;
      r_timeout_err <= 1'b0;
      r_retry       <= '0;
    end else if (w_seq_start) begin
      r_got         <= '0;
      r_detected    <= '0;
      r_timeout_err <= 1'b0;
      r_retry       <= '0;
    end else begin
      if (w_retry) begin
        r_got   <= '0;
        r_retry <= r_retry + 1'b1;
      end else if (r_state == S_DETECT) begin
        r_got <= w_got_nxt;
      end
      r_detected <= r_detected | (w_new_status & w_rx_ok);
      if (w_timeout_hit) r_timeout_err <= 1'b1;
    end
  end

  assign o_power_down            = {LANESNUMBER{PD_P1}};
  assign o_tx_elec_idle          = '1;
  assign o_tx_detect_rx_loopback = w_loopback;
  assign o_busy                  = (r_state != S_IDLE);
  assign o_done                  = (r_state == S_DONE);
  assign o_detected_lanes        = r_detected;
  assign o_timeout_err           = r_timeout_err;

endmodule

// File: tb/tb_pipe_rx_detect_seq.sv
// Bench for pipe_rx_detect_seq: directed scenarios, a phase-level reference
// model checked against the DUT on every negedge, plus literal checks per scenario.
module tb_pipe_rx_detect_seq;
  localparam int L  = 16;
  localparam int SC = 8;
  localparam int TO = 1024;
  localparam int RM = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [L-1:0]  phy = '0;
  logic [3*L-1:0] rx = '0;
  logic [L-1:0]  lane_enable = '1;
  logic [4*L-1:0] pd;
  logic [L-1:0]  eidle, lb, det;
  logic          busy, done, terr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_rx_detect_seq #(.LANESNUMBER(L), .SETUP_CYCLES(SC), .TIMEOUT_CYCLES(TO), .RETRY_MAX(RM)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_phy_status(phy), .i_rx_status(rx),
`ifdef RXDET_LANE_MASK_EN
    .i_lane_enable(lane_enable),
`endif
    .o_power_down(pd), .o_tx_elec_idle(eidle), .o_tx_detect_rx_loopback(lb),
    .o_busy(busy), .o_done(done), .o_detected_lanes(det), .o_timeout_err(terr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 setup, 2 detect, 3 release, 4 done.
  int           m_phase = 0;
  int           m_cyc = 0;
  int           m_retry = 0;
  logic [L-1:0] m_en = '1, m_got = '0, m_det = '0;
  logic         m_terr = 1'b0;
  bit           m_valid = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_cyc = 0; m_retry = 0; m_got = '0; m_det = '0; m_terr = 0; m_valid = 1;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase = 1; m_cyc = 0; m_retry = 0; m_got = '0; m_det = '0; m_terr = 0;
`ifdef RXDET_LANE_MASK_EN
          m_en = lane_enable;
`else
          m_en = '1;
`endif
        end
        1: begin
          m_cyc++;
          if (m_cyc == SC) begin m_phase = 2; m_cyc = 0; end
        end
        2: begin
          for (int l = 0; l < L; l++)
            if (phy[l] && m_en[l] && !m_got[l]) begin
              m_got[l] = 1'b1;
              m_det[l] = (((rx >> (3*l)) & 48'h7) == 48'h3);
            end
          m_cyc++;
          if ((m_got & m_en) == m_en) m_phase = 3;
          else if (m_cyc == TO) begin m_phase = 3; m_terr = 1'b1; end
        end
        3: begin
          if (m_det == '0 && m_retry < RM && !m_terr) begin
            m_retry++; m_got = '0; m_phase = 1; m_cyc = 0;
          end else m_phase = 4;
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison plus activity counters for the scenario checks.
  int n_done = 0, n_lb = 0, n_pass = 0;
  logic lb_prev = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("m_loopback", lb, (m_phase == 2) ? m_en : '0);
      check("m_busy", busy, m_phase != 0);
      check("m_done", done, m_phase == 4);
      check("m_detected", det, m_det);
      check("m_timeout_err", terr, m_terr);
      check("m_power_down", pd, {L{4'b0010}});
      check("m_elec_idle", eidle, {L{1'b1}});
    end
    n_done += int'(done);
    n_lb   += int'(lb != '0);
    n_pass += int'(lb != '0 && !lb_prev);
    lb_prev = (lb != '0);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input logic [L-1:0] en);
    start = 1'b1; lane_enable = en;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_lb();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = (lb != '0);
    end
    check("wait_detect_phase", ok, 1'b1);
  endtask

  task automatic pulse_phy(input logic [L-1:0] p, input logic [3*L-1:0] r);
    phy = p; rx = r;
    tick();
    phy = '0; rx = '0;
  endtask

  task automatic wait_done(input int lim);
    bit ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = done;
    end
    check("wait_done", ok, 1'b1);
    tick(2);
  endtask

  function automatic logic [3*L-1:0] mk_rx(input logic [L-1:0] m);
    logic [3*L-1:0] r = '0;
    for (int l = 0; l < L; l++) if (m[l]) r[3*l +: 3] = 3'b011;
    return r;
  endfunction

  int d0, l0, p0;
  task automatic snap();
    d0 = n_done; l0 = n_lb; p0 = n_pass;
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    tick();
    check("reset_busy", busy, 1'b0);
    check("reset_lb", lb, 16'h0);
    check("reset_pd", pd, 64'h2222_2222_2222_2222);
    check("reset_eidle", eidle, 16'hFFFF);
    check("reset_det", det, 16'h0);

    // All lanes present, response 5 cycles into DETECT; extra start while busy ignored.
    snap(); do_start('1);
    start = 1'b1; tick(); start = 1'b0;
    wait_lb(); tick(4); pulse_phy(16'hFFFF, mk_rx(16'hFFFF)); wait_done(50);
    check("all_det", det, 16'hFFFF);
    check("all_terr", terr, 1'b0);
    check("all_done_cnt", n_done - d0, 1);
    check("all_lb_cycles", n_lb - l0, 5);
    check("all_passes", n_pass - p0, 1);

    // Lanes 0-3 present only.
    snap(); do_start('1);
    wait_lb(); tick(4); pulse_phy(16'hFFFF, mk_rx(16'h000F)); wait_done(50);
    check("low4_det", det, 16'h000F);
    check("low4_done_cnt", n_done - d0, 1);
    check("low4_passes", n_pass - p0, 1);

    // Nothing present: one retry pass, then done with empty mask.
    snap(); do_start('1);
    wait_lb(); tick(4); pulse_phy(16'hFFFF, '0);
    wait_lb(); tick(4); pulse_phy(16'hFFFF, '0); wait_done(50);
    check("empty_det", det, 16'h0);
    check("empty_terr", terr, 1'b0);
    check("empty_passes", n_pass - p0, 2);
    check("empty_lb_cycles", n_lb - l0, 10);
    check("empty_done_cnt", n_done - d0, 1);

    // Lane 15 silent; repeated PhyStatus on lane 0 must not overwrite it.
    snap(); do_start('1);
    wait_lb(); tick(4); pulse_phy(16'h7FFF, mk_rx(16'h7FFF));
    pulse_phy(16'h0001, '0); wait_done(TO + 50);
    check("to_det", det, 16'h7FFF);
    check("to_terr", terr, 1'b1);
    check("to_lb_cycles", n_lb - l0, TO);
    check("to_passes", n_pass - p0, 1);
    check("to_done_cnt", n_done - d0, 1);

    // Completion on the very last DETECT cycle beats the timeout.
    snap(); do_start('1);
    wait_lb(); tick(TO - 1); pulse_phy(16'hFFFF, mk_rx(16'hFFFF)); wait_done(50);
    check("edge_terr", terr, 1'b0);
    check("edge_det", det, 16'hFFFF);
    check("edge_lb_cycles", n_lb - l0, TO);

    // Reset in the middle of DETECT.
    snap(); do_start('1);
    wait_lb(); tick(2);
    reset = 1'b1; tick();
    check("rst_lb", lb, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_pd", pd, 64'h2222_2222_2222_2222);
    check("rst_det", det, 16'h0);
    reset = 1'b0; tick(3);
    check("rst_done_cnt", n_done - d0, 0);

`ifdef RXDET_LANE_MASK_EN
    snap(); do_start(16'h00FF);
    wait_lb();
    check("mask_lb", lb, 16'h00FF);
    tick(4); pulse_phy(16'hFFFF, mk_rx(16'hFFFF)); wait_done(50);
    check("mask_det", det, 16'h00FF);
    check("mask_done_cnt", n_done - d0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
